// File: rtl/regfile_wr_arbiter.sv
// Two-requester register-file write arbiter with per-requester holding slots and zero-register drop counting.
// Define REGFILE_WR_RR_EN for round-robin arbitration; otherwise slot 0 has fixed priority.
module regfile_wr_arbiter #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ZR_ADDR = 31
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    input  logic [4:0]        req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [4:0]        req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              we3,
    output logic [4:0]        wa3,
    output logic [DATA_W-1:0] wd3,
    output logic              busy,
    output logic [7:0]        zr_drop_cnt
);

    localparam logic [4:0] ZR = 5'(ZR_ADDR);

    logic              full0, full1;
    logic [4:0]        addr0, addr1;
    logic [DATA_W-1:0] data0, data1;
    logic              age0, age1;

`ifdef REGFILE_WR_RR_EN
    typedef enum logic {SLOT0 = 1'b0, SLOT1 = 1'b1} slot_e;
    slot_e rr_ptr;
`endif

    logic gnt0, gnt1;
    logic acc0, acc1;
    logic zr0, zr1;
    logic ld0, ld1;
    logic stay0, stay1;
    logic [1:0] zr_inc;
    logic [8:0] cnt_sum;

    // age bit set means "younger than the other slot's occupant"; with both
    // slots full exactly one of them is set
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (full0 && full1) begin
            if (addr0 == addr1) begin
                gnt0 = ~age0;
                gnt1 = age0;
            end else begin
`ifdef REGFILE_WR_RR_EN
                gnt0 = (rr_ptr == SLOT0);
                gnt1 = (rr_ptr == SLOT1);
`else
                gnt0 = 1'b1;
`endif
            end
        end else begin
            gnt0 = full0;
            gnt1 = full1;
        end
    end

    assign req0_ready = ~full0 | gnt0;
    assign req1_ready = ~full1 | gnt1;
    assign busy       = full0 | full1;

    assign acc0  = req0_valid & req0_ready;
    assign acc1  = req1_valid & req1_ready;
    assign zr0   = acc0 & (req0_addr == ZR);
    assign zr1   = acc1 & (req1_addr == ZR);
    assign ld0   = acc0 & ~zr0;
    assign ld1   = acc1 & ~zr1;
    assign stay0 = full0 & ~gnt0;
    assign stay1 = full1 & ~gnt1;

    assign zr_inc  = {1'b0, zr0} + {1'b0, zr1};
    assign cnt_sum = {1'b0, zr_drop_cnt} + {7'b0, zr_inc};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full0       <= 1'b0;
            full1       <= 1'b0;
            addr0       <= '0;
            addr1       <= '0;
            data0       <= '0;
            data1       <= '0;
            age0        <= 1'b0;
            age1        <= 1'b0;
            we3         <= 1'b0;
            wa3         <= '0;
            wd3         <= '0;
            zr_drop_cnt <= '0;
`ifdef REGFILE_WR_RR_EN
            rr_ptr      <= SLOT0;
`endif
        end else begin
            we3 <= gnt0 | gnt1;
            if (gnt0) begin
                wa3 <= addr0;
                wd3 <= data0;
            end else if (gnt1) begin
                wa3 <= addr1;
                wd3 <= data1;
            end

`ifdef REGFILE_WR_RR_EN
            if (gnt0 || gnt1)
                rr_ptr <= gnt0 ? SLOT1 : SLOT0;
`endif

            if (ld0) begin
                full0 <= 1'b1;
                addr0 <= req0_addr;
                data0 <= req0_data;
            end else if (gnt0) begin
                full0 <= 1'b0;
            end

            if (ld1) begin
                full1 <= 1'b1;
                addr1 <= req1_addr;
                data1 <= req1_data;
            end else if (gnt1) begin
                full1 <= 1'b0;
            end

            // a refilled slot is younger than a surviving neighbour; same-cycle loads put slot 0 first
            if (ld0)
                age0 <= stay1;
            else if (ld1)
                age0 <= 1'b0;
            if (ld1)
                age1 <= stay0 | ld0;
            else if (ld0)
                age1 <= 1'b0;

            zr_drop_cnt <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
        end
    end

endmodule
